// File: rtl/data_route_if.sv
// Board-facing signal bundle for data_route: display/step controls in, multiplexed 7-segment drive out.
interface data_route_if;
    logic [5:0] ram_addr_display;
    logic       frequency;
    logic [2:0] display;
    logic       continue_req;
    logic [7:0] AN;
    logic [7:0] SEG;

    modport master (
        output ram_addr_display, frequency, display, continue_req,
        input  AN, SEG
    );

    modport slave (
        input  ram_addr_display, frequency, display, continue_req,
        output AN, SEG
    );
endinterface

// File: rtl/data_route.sv
// Writes the triangular-number sequence into a 64-word RAM under run/halt control and scans a selected value onto 8 hex digits.
// Define BREAKPOINT_EN to halt automatically every HALT_INTERVAL steps and resume on a rising edge of continue_req.
module data_route #(
    parameter int DIV_BITS      = 20,
    parameter int HALT_INTERVAL = 16,
    parameter int SCAN_BITS     = 10
) (
    input logic         clk,
    input logic         rst,
    data_route_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [31:0] HALT_MASK = 32'(HALT_INTERVAL - 1);

    state_t                 state, state_next;
    logic                   step_en, do_step, do_halt, cont_edge;
    logic [DIV_BITS-1:0]    divider;
    logic [SCAN_BITS-1:0]   scan;
    logic [31:0]            acc, step, halts, step_plus1;
    logic [5:0]             wp;
    logic [31:0]            ram [64];
    logic [31:0]            value;
    logic [2:0]             digit;
    logic [3:0]             nibble;
    logic [7:0]             an_q, seg_q;

    function automatic logic [6:0] seg7(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef BREAKPOINT_EN
    // Two synchroniser flops, then a third holding the previous sample for edge detection.
    logic [2:0] cont_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cont_sync <= '0;
        else      cont_sync <= {cont_sync[1:0], bus.continue_req};
    end

    assign cont_edge = cont_sync[1] & ~cont_sync[2];
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.continue_req, HALT_MASK};
    assign cont_edge  = 1'b0;
`endif

    assign step_en    = bus.frequency | (divider == '1);
    assign step_plus1 = step + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        do_step    = 1'b0;
        do_halt    = 1'b0;
        case (state)
            RUN: begin
                if (step_en) begin
                    do_step = 1'b1;
`ifdef BREAKPOINT_EN
                    if ((step_plus1 & HALT_MASK) == 32'd0) begin
                        do_halt    = 1'b1;
                        state_next = HALT;
                    end
`endif
                end
            end
            HALT: begin
                if (cont_edge) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divider <= '0;
            scan    <= '0;
        end else begin
            divider <= divider + 1'b1;
            scan    <= scan + 1'b1;
        end
    end

    // NOTE: the RAM must read back as zero after reset, so it is built from resettable flops rather than a block RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            step  <= '0;
            wp    <= '0;
            halts <= '0;
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else begin
            if (do_step) begin
                ram[wp] <= acc;
                acc     <= acc + step_plus1;
                wp      <= wp + 6'd1;
                step    <= step_plus1;
            end
            if (do_halt) halts <= halts + 32'd1;
        end
    end

    always_comb begin
        value = '0;
        case (bus.display)
            3'd0:    value = ram[bus.ram_addr_display];
            3'd1:    value = acc;
            3'd2:    value = step;
            3'd3:    value = halts;
            3'd4:    value = {26'b0, wp};
            3'd5:    value = {31'b0, state == HALT};
            default: value = '0;
        endcase
    end

    assign digit  = scan[SCAN_BITS-1 -: 3];
    assign nibble = value[4*digit +: 4];

    // Registered drive keeps the pins glitch-free; digit selection lags scan by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 8'hFE;
            seg_q <= 8'hC0;
        end else begin
            an_q  <= ~(8'b1 << digit);
            seg_q <= {1'b1, ~seg7(nibble)};
        end
    end

    assign bus.AN  = an_q;
    assign bus.SEG = seg_q;

endmodule

// File: tb/tb_data_route.sv
// Directed bench for data_route: values are read back by decoding one full aligned scan of the 7-segment outputs.
module tb_data_route;

    logic clk;
    logic rst;

    data_route_if bus();

    data_route #(
        .DIV_BITS      (3),
        .HALT_INTERVAL (16),
        .SCAN_BITS     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [5:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t run_tab[15];
    vec_t ram_tab[4];
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] seg_to_hex(input logic [7:0] seg);
        logic [6:0] pat;
        logic [3:0] h;
        pat = ~seg[6:0];
        case (pat)
            7'h3F: h = 4'h0;  7'h06: h = 4'h1;  7'h5B: h = 4'h2;  7'h4F: h = 4'h3;
            7'h66: h = 4'h4;  7'h6D: h = 4'h5;  7'h7D: h = 4'h6;  7'h07: h = 4'h7;
            7'h7F: h = 4'h8;  7'h6F: h = 4'h9;  7'h77: h = 4'hA;  7'h7C: h = 4'hB;
            7'h39: h = 4'hC;  7'h5E: h = 4'hD;  7'h79: h = 4'hE;  7'h71: h = 4'hF;
            default: h = 4'bxxxx;
        endcase
        if (seg[7] !== 1'b1) h = 4'bxxxx;
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for digit 7 to be on show, then captures digits 0..7 of the selected value over the next 8 clocks.
    task automatic read_check(input string name, input logic [2:0] sel, input logic [5:0] addr,
                              input logic [31:0] exp);
        logic [31:0] val;
        logic        an_ok;
        logic [7:0]  an_exp;
        int          waited;
        val    = '0;
        an_ok  = 1'b1;
        waited = 0;
        while (bus.AN !== 8'h7F && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.AN !== 8'h7F) an_ok = 1'b0;
        bus.display          = sel;
        bus.ram_addr_display = addr;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            an_exp = ~(8'h01 << i);
            if (bus.AN !== an_exp) an_ok = 1'b0;
            val[4*i +: 4] = seg_to_hex(bus.SEG);
        end
        check({name, " value"}, val, exp);
        check({name, " scan"}, {31'b0, an_ok}, 32'd1);
    endtask

    task automatic pulse_continue();
        bus.continue_req = 1'b1;
        @(negedge clk);
        bus.continue_req = 1'b0;
    endtask

    initial begin
        // Slow stepping: one step per 8-clock scan, so entry r sees the state after r+1 steps.
        run_tab[0]  = '{"acc n1",     3'd1, 6'd0,  32'd1};
        run_tab[1]  = '{"step n2",    3'd2, 6'd0,  32'd2};
        run_tab[2]  = '{"acc n3",     3'd1, 6'd0,  32'd6};
        run_tab[3]  = '{"wp n4",      3'd4, 6'd0,  32'd4};
        run_tab[4]  = '{"ram3 n5",    3'd0, 6'd3,  32'd6};
        run_tab[5]  = '{"state n6",   3'd5, 6'd0,  32'd0};
        run_tab[6]  = '{"halts n7",   3'd3, 6'd0,  32'd0};
        run_tab[7]  = '{"sel6 n8",    3'd6, 6'd0,  32'd0};
        run_tab[8]  = '{"sel7 n9",    3'd7, 6'd0,  32'd0};
        run_tab[9]  = '{"ram9 n10",   3'd0, 6'd9,  32'd45};
        run_tab[10] = '{"ram11 n11",  3'd0, 6'd11, 32'd0};
        run_tab[11] = '{"acc n12",    3'd1, 6'd0,  32'd78};
        run_tab[12] = '{"step n13",   3'd2, 6'd0,  32'd13};
        run_tab[13] = '{"ram13 n14",  3'd0, 6'd13, 32'd91};
        run_tab[14] = '{"wp n15",     3'd4, 6'd0,  32'd15};

        ram_tab[0]  = '{"ram17", 3'd0, 6'd17, 32'h0000_0099};
        ram_tab[1]  = '{"ram18", 3'd0, 6'd18, 32'h0000_00AB};
        ram_tab[2]  = '{"ram24", 3'd0, 6'd24, 32'h0000_012C};
        ram_tab[3]  = '{"ram26", 3'd0, 6'd26, 32'h0000_015F};

        rst                  = 1'b0;
        bus.frequency        = 1'b0;
        bus.display          = 3'd0;
        bus.ram_addr_display = 6'd0;
        bus.continue_req     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset AN", {24'b0, bus.AN}, 32'hFE);
        for (int d = 0; d < 8; d++) begin
            bus.display = 3'(d);
            @(negedge clk);
            check($sformatf("reset SEG sel%0d", d), {24'b0, bus.SEG}, 32'hC0);
        end

        rst = 1'b1;
        for (int r = 0; r < 15; r++)
            read_check(run_tab[r].name, run_tab[r].sel, run_tab[r].addr, run_tab[r].exp);

`ifdef BREAKPOINT_EN
        read_check("halt state",  3'd5, 6'd0,  32'd1);
        read_check("halt step",   3'd2, 6'd0,  32'd16);
        read_check("halt wp",     3'd4, 6'd0,  32'd16);
        read_check("halt acc",    3'd1, 6'd0,  32'd136);
        read_check("halt count",  3'd3, 6'd0,  32'd1);
        read_check("halt ram15",  3'd0, 6'd15, 32'd120);
        read_check("halt ram3",   3'd0, 6'd3,  32'd6);

        bus.frequency = 1'b1;
        pulse_continue();
        repeat (6) @(negedge clk);
        pulse_continue();
        repeat (30) @(negedge clk);
        read_check("cont state",  3'd5, 6'd0, 32'd1);
        read_check("cont step",   3'd2, 6'd0, 32'd32);
        read_check("cont acc",    3'd1, 6'd0, 32'd528);
        read_check("cont halts",  3'd3, 6'd0, 32'd2);

        for (int k = 0; k < 2; k++) begin
            pulse_continue();
            repeat (30) @(negedge clk);
        end
        read_check("wrap wp",     3'd4, 6'd0, 32'd0);
        read_check("wrap step",   3'd2, 6'd0, 32'd64);
        read_check("wrap halts",  3'd3, 6'd0, 32'd4);

        pulse_continue();
        repeat (30) @(negedge clk);
        read_check("wrap ram0",   3'd0, 6'd0, 32'h0000_0820);
        read_check("wrap ram1",   3'd0, 6'd1, 32'd2145);
        read_check("wrap step80", 3'd2, 6'd0, 32'd80);
`else
        read_check("free step n16",  3'd2, 6'd0, 32'd16);
        read_check("free state n17", 3'd5, 6'd0, 32'd0);
        read_check("free halts n18", 3'd3, 6'd0, 32'd0);

        // Five clocks at full rate plus the divider step at the end of the same scan: 19 -> 25.
        bus.frequency = 1'b1;
        repeat (5) @(negedge clk);
        bus.frequency = 1'b0;
        read_check("burst step",     3'd2, 6'd0, 32'd25);

        repeat (38 * 8) @(negedge clk);
        read_check("wrap wp n64",    3'd4, 6'd0, 32'd0);
        read_check("wrap ram0 n65",  3'd0, 6'd0, 32'h0000_0820);
        read_check("wrap acc n66",   3'd1, 6'd0, 32'd2211);
`endif

        for (int r = 0; r < 4; r++)
            read_check(ram_tab[r].name, ram_tab[r].sel, ram_tab[r].addr, ram_tab[r].exp);

        bus.frequency = 1'b0;
        bus.display   = 3'd1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async reset AN",  {24'b0, bus.AN},  32'hFE);
        check("async reset SEG", {24'b0, bus.SEG}, 32'hC0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        read_check("rerun step n1",  3'd2, 6'd0, 32'd1);
        read_check("rerun ram5 n2",  3'd0, 6'd5, 32'd0);
        read_check("rerun acc n3",   3'd1, 6'd0, 32'd6);
        read_check("rerun halts n4", 3'd3, 6'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
